sram_page_arbiter: RTL
======================

// Module: sram_page_arbiter
// PURPOSE
//  Shared page allocator for the 32-bank packet SRAM. Arbitrates page-allocation requests from REQ_NUM
//  ingress address generators (round-robin). Each bank is a ring of PAGE_NUM 64-byte pages. A grant
//  reserves a contiguous run (modulo PAGE_NUM) in the lowest-indexed bank with enough free pages.
//  Dequeue returns freed pages. Publishes the per-bank free count and next-free pointer to all requesters.
// PARAMETERS
//  REQ_NUM   4    number of requesters (2..16)
//  SRAM_NUM  32   number of SRAM banks
//  PAGE_NUM  128  pages per bank; free counters reset to this value
//  PG_W      7    width of page-count/length fields (must hold PAGE_NUM-1)
// PORTS
//  sys_clk        in   1              system clock, all logic rising-edge
//  sys_rst_n      in   1              asynchronous active-low reset
//  req            in   REQ_NUM        allocation request, level; held until matching req_done
//  req_pages      in   REQ_NUM*PG_W   pages wanted, slice i for requester i; stable while req[i]=1
//  req_done       out  REQ_NUM        one-cycle grant/complete pulse to the served requester
//  alloc_vld      out  1              one-cycle pulse, coincident with req_done
//  alloc_fail     out  1              with alloc_vld: no bank could satisfy the request; no state change
//  alloc_sram     out  5              granted bank index (valid with alloc_vld & !alloc_fail)
//  alloc_addr     out  9              granted start page {2'b0,ptr}; run wraps modulo PAGE_NUM
//  rel_vld        in   1              release pulse from dequeue side; accepted every cycle
//  rel_sram       in   5              bank being released
//  rel_pages      in   PG_W           pages freed (in allocation order per bank)
//  sram_idle_cnt  out  9*SRAM_NUM     registered free-page count, bank b at [9b+8:9b]
//  sram_addr      out  9*SRAM_NUM     registered next-free pointer, bank b at [9b+8:9b]
//  err_rel_ovf    out  1              sticky: a release pushed a count above PAGE_NUM
// BEHAVIOUR
//  Reset (async assert, sync deassert): FSM=IDLE; req_done, alloc_vld, alloc_fail, err_rel_ovf = 0.
//   alloc_sram, alloc_addr = 0. Every idle_cnt = PAGE_NUM. Every wr_ptr and rd_ptr = 0. rr pointer = 0.
//  FSM (one-hot): IDLE -> ARB when |req. ARB -> LOOKUP. LOOKUP -> GRANT. GRANT -> IDLE.
//  ARB: round-robin pick starting at rr_ptr. Register winner and its req_pages. rr_ptr <= winner+1 (wraps at REQ_NUM).
//  LOOKUP: choose the lowest bank b with idle_cnt[b] >= pages. Register b and hit flag.
//   pages==0 or pages>PAGE_NUM -> forced miss.
//  GRANT: req_done[winner]=1 and alloc_vld=1 for exactly this cycle.
//   On hit: alloc_fail=0, alloc_sram=b, alloc_addr=wr_ptr[b].
//    wr_ptr[b] <= (wr_ptr[b]+pages) mod PAGE_NUM; idle_cnt[b] -= pages.
//   On miss: alloc_fail=1; counters unchanged; requester retries by re-raising req.
//  Latency: req high in IDLE -> req_done 3 cycles later (IDLE sample, ARB, LOOKUP, GRANT).
//   Next arbitration can start the cycle after GRANT.
//  Requester must drop req the cycle after req_done. A req still high in IDLE is a new request.
//  Release: rel_vld -> rd_ptr[s] += rel_pages (mod), idle_cnt[s] += rel_pages, applied the following cycle.
//  Same bank, same cycle, GRANT and release: idle_cnt <= idle_cnt - pages + rel_pages (single update, no loss).
//  Release overflow (result > PAGE_NUM): clamp to PAGE_NUM, set err_rel_ovf; it clears only on reset.
//  rel_pages==0 is a no-op. LOOKUP uses counts registered before any same-cycle release (conservative).
//  Arithmetic: counts are 9-bit unsigned; ptr math is PG_W-bit with explicit mod PAGE_NUM (PAGE_NUM power of 2 -> natural wrap).
//  Published sram_idle_cnt/sram_addr reflect register state; visible 1 cycle after the update edge.
// STRUCTURE
//  Package sram_arb_pkg: SRAM_NUM, PAGE_NUM, PG_W, CNT_W=9, BANK_W=5, FSM state encodings.
//  Sub-module rr_arbiter #(N): req vector + rr_ptr -> one-hot grant + index, combinational; ptr reg in parent.
//  Parent holds FSM, per-bank counter/pointer arrays (generate loop), first-fit priority encoder.
// TESTING
//  1 Reset, req[0]=1 pages=5 -> req_done[0] at cycle 3, sram=0 addr=0; idle_cnt[0]=123, sram_addr[0]=5.
//  2 Bank0 idle=3, bank1 full, request 4 pages -> sram=1 addr=0; bank0 untouched.
//  3 req=4'b1111 held continuously -> grants in order 0,1,2,3,0; each req_done one cycle, 4 cycles apart.
//  4 All banks idle<10, request 10 -> alloc_fail=1, counts unchanged. Also pages=0 -> fail.
//  5 wr_ptr[2]=126, grant 4 pages -> addr=126, wr_ptr=2. Same-cycle release 3 on bank 2 -> idle net -1.
//  6 Release 2 pages to a full bank -> idle stays 128, err_rel_ovf=1. sys_rst_n low mid-LOOKUP -> IDLE, all reset values.

Source files
------------

// File: rtl/sram_page_arbiter_pkg.sv
// Shared constants for the packet SRAM page allocator: geometry, field
// widths and the one-hot FSM state encodings.
package sram_arb_pkg;

  localparam int SRAM_NUM = 32;
  localparam int PAGE_NUM = 128;
  localparam int PG_W     = 7;
  localparam int CNT_W    = 9;
  localparam int BANK_W   = 5;

  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_ARB    = 4'b0010;
  localparam logic [3:0] ST_LOOKUP = 4'b0100;
  localparam logic [3:0] ST_GRANT  = 4'b1000;

endpackage

// File: rtl/sram_page_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr (wrapping at N) wins. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] cand;

  // Walk the requesters starting at ptr and keep the first one that is asserted.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!any && req[cand[IW-1:0]]) begin
        any = 1'b1;
        idx = cand[IW-1:0];
      end
    end
    if (any) grant = N'(1) << idx;
  end

endmodule

// File: rtl/sram_page_arbiter.sv
// Page allocator for the banked packet SRAM. Requests are arbitrated
// round-robin, then granted a contiguous page run in the lowest bank with
// enough free pages. Releases from the dequeue side return pages.
module sram_page_arbiter
  import sram_arb_pkg::*;
#(
  parameter int REQ_NUM = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [REQ_NUM-1:0]         req,
  input  logic [REQ_NUM*PG_W-1:0]    req_pages,
  output logic [REQ_NUM-1:0]         req_done,
  output logic                       alloc_vld,
  output logic                       alloc_fail,
  output logic [BANK_W-1:0]          alloc_sram,
  output logic [CNT_W-1:0]           alloc_addr,
  input  logic                       rel_vld,
  input  logic [BANK_W-1:0]          rel_sram,
  input  logic [PG_W-1:0]            rel_pages,
  output logic [CNT_W*SRAM_NUM-1:0]  sram_idle_cnt,
  output logic [CNT_W*SRAM_NUM-1:0]  sram_addr,
  output logic                       err_rel_ovf
);

  localparam int IW    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int SUM_W = CNT_W + 1;

  logic [3:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [REQ_NUM-1:0] grant_q;
  logic [PG_W-1:0]    pages_q;
  logic [BANK_W-1:0]  bank_q;
  logic               hit_q;

  logic [REQ_NUM-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic [SRAM_NUM-1:0][CNT_W-1:0] cnt_vec;
  logic [SRAM_NUM-1:0][PG_W-1:0]  ptr_vec;
  logic [SRAM_NUM-1:0]            ovf_vec;

  logic               fit_hit;
  logic [BANK_W-1:0]  fit_bank;
  logic               pages_ok;

  rr_arbiter #(.N(REQ_NUM), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign pages_ok = (pages_q != '0) && (CNT_W'(pages_q) <= CNT_W'(PAGE_NUM));

  // First-fit search: lowest bank whose registered free count covers the request.
  always_comb begin
    fit_hit  = 1'b0;
    fit_bank = '0;
    for (int b = 0; b < SRAM_NUM; b++) begin
      if (!fit_hit && pages_ok && (cnt_vec[b] >= CNT_W'(pages_q))) begin
        fit_hit  = 1'b1;
        fit_bank = BANK_W'(b);
      end
    end
  end

  // Request FSM: sample, arbitrate, look up a bank, then pulse the grant outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      pages_q    <= '0;
      bank_q     <= '0;
      hit_q      <= 1'b0;
      req_done   <= '0;
      alloc_vld  <= 1'b0;
      alloc_fail <= 1'b0;
      alloc_sram <= '0;
      alloc_addr <= '0;
    end else begin
      req_done   <= '0;
      alloc_vld  <= 1'b0;
      alloc_fail <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) state <= ST_ARB;
        end
        ST_ARB: begin
          if (arb_any) begin
            grant_q <= arb_grant;
            pages_q <= req_pages[arb_idx*PG_W +: PG_W];
            rr_ptr  <= (arb_idx == IW'(REQ_NUM - 1)) ? '0 : arb_idx + IW'(1);
            state   <= ST_LOOKUP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOOKUP: begin
          hit_q      <= fit_hit;
          bank_q     <= fit_bank;
          req_done   <= grant_q;
          alloc_vld  <= 1'b1;
          alloc_fail <= !fit_hit;
          if (fit_hit) begin
            alloc_sram <= fit_bank;
            alloc_addr <= CNT_W'(ptr_vec[fit_bank]);
          end
          state <= ST_GRANT;
        end
        ST_GRANT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar b = 0; b < SRAM_NUM; b++) begin : g_bank
    logic [CNT_W-1:0] cnt_q;
    logic [PG_W-1:0]  wr_q;
    logic [PG_W-1:0]  rd_q;
    logic             take;
    logic             give;
    logic [SUM_W-1:0] sum;

    assign take = (state == ST_GRANT) && hit_q && (bank_q == BANK_W'(b));
    assign give = rel_vld && (rel_sram == BANK_W'(b)) && (rel_pages != '0);
    assign sum  = {1'b0, cnt_q}
                - (take ? SUM_W'(pages_q)   : '0)
                + (give ? SUM_W'(rel_pages) : '0);
    assign ovf_vec[b] = give && (sum > SUM_W'(PAGE_NUM));

    // Bank counters: a grant and a release in the same cycle fold into one update.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        cnt_q <= CNT_W'(PAGE_NUM);
        wr_q  <= '0;
        rd_q  <= '0;
      end else begin
        if (take || give) cnt_q <= ovf_vec[b] ? CNT_W'(PAGE_NUM) : sum[CNT_W-1:0];
        if (take) wr_q <= wr_q + pages_q;
        if (give) rd_q <= rd_q + rel_pages;
      end
    end

    assign cnt_vec[b] = cnt_q;
    assign ptr_vec[b] = wr_q;
    assign sram_idle_cnt[b*CNT_W +: CNT_W] = cnt_q;
    assign sram_addr[b*CNT_W +: CNT_W]     = CNT_W'(wr_q);
  end

  // Sticky release-overflow flag; only reset clears it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) err_rel_ovf <= 1'b0;
    else if (|ovf_vec) err_rel_ovf <= 1'b1;
  end

endmodule
